// File: rtl/clock_pkg.sv
// Shared time-of-day widths and limits used by the set, keep and display stages.
package clock_pkg;

    localparam int HOURS_W = 5;
    localparam int MIN_W   = 6;
    localparam int SEC_W   = 6;

    localparam logic [HOURS_W-1:0] HOURS_MAX = 5'd23;
    localparam logic [MIN_W-1:0]   MIN_MAX   = 6'd59;
    localparam logic [SEC_W-1:0]   SEC_MAX   = 6'd59;

    typedef struct packed {
        logic [HOURS_W-1:0] hours;
        logic [MIN_W-1:0]   minutes;
        logic [SEC_W-1:0]   seconds;
    } hms_t;

    // Out-of-range loads go to zero rather than wrapping modulo.
    function automatic logic [HOURS_W-1:0] clamp_hours(input logic [HOURS_W-1:0] h);
        return (h <= HOURS_MAX) ? h : '0;
    endfunction

    function automatic logic [MIN_W-1:0] clamp_minutes(input logic [MIN_W-1:0] m);
        return (m <= MIN_MAX) ? m : '0;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides clk down to a one-cycle tick every CLK_DIV cycles; clr restarts the count.
module tick_prescaler #(
    parameter int CLK_DIV = 50_000_000,
    parameter int DIV_W   = $clog2(CLK_DIV)
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam logic [DIV_W-1:0] TERM_CNT = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] cnt_q, cnt_d;

    // Tick is combinational so the seconds register updates on the same edge the count wraps.
    always_comb begin
        tick  = 1'b0;
        cnt_d = cnt_q + DIV_W'(1);
        if (clr) begin
            cnt_d = '0;
        end else if (cnt_q == TERM_CNT) begin
            cnt_d = '0;
            tick  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end

endmodule

// File: rtl/time_keeper.sv
// 24-hour HH:MM:SS counter fed by the set stage; loads on a rising load edge, freezes on hold.
module time_keeper
    import clock_pkg::*;
#(
    parameter int CLK_DIV = 50_000_000,
    parameter int DIV_W   = $clog2(CLK_DIV)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               hold,
    input  logic               load,
    input  logic [HOURS_W-1:0] i_hours,
    input  logic [MIN_W-1:0]   i_minutes,
    output logic [HOURS_W-1:0] o_hours,
    output logic [MIN_W-1:0]   o_minutes,
    output logic [SEC_W-1:0]   o_seconds,
    output logic               o_sec_pulse,
    output logic               o_day_wrap
);

    hms_t time_q, time_d;
    logic load_q, load_d;
    logic sec_pulse_q, sec_pulse_d;
    logic day_wrap_q, day_wrap_d;
    logic load_rise;
    logic tick;

    assign load_rise = load & ~load_q;
    assign load_d    = load;

    tick_prescaler #(
        .CLK_DIV (CLK_DIV),
        .DIV_W   (DIV_W)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .clr  (hold | load_rise),
        .tick (tick)
    );

    // A load on the same edge as a tick wins; the tick is simply dropped.
    always_comb begin
        time_d      = time_q;
        sec_pulse_d = 1'b0;
        day_wrap_d  = 1'b0;
        if (load_rise) begin
            time_d.hours   = clamp_hours(i_hours);
            time_d.minutes = clamp_minutes(i_minutes);
            time_d.seconds = '0;
        end else if (tick) begin
            sec_pulse_d = 1'b1;
            if (time_q.seconds == SEC_MAX) begin
                time_d.seconds = '0;
                if (time_q.minutes == MIN_MAX) begin
                    time_d.minutes = '0;
                    if (time_q.hours == HOURS_MAX) begin
                        time_d.hours = '0;
                        day_wrap_d   = 1'b1;
                    end else begin
                        time_d.hours = time_q.hours + HOURS_W'(1);
                    end
                end else begin
                    time_d.minutes = time_q.minutes + MIN_W'(1);
                end
            end else begin
                time_d.seconds = time_q.seconds + SEC_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            time_q      <= '0;
            load_q      <= 1'b0;
            sec_pulse_q <= 1'b0;
            day_wrap_q  <= 1'b0;
        end else begin
            time_q      <= time_d;
            load_q      <= load_d;
            sec_pulse_q <= sec_pulse_d;
            day_wrap_q  <= day_wrap_d;
        end
    end

    assign o_hours     = time_q.hours;
    assign o_minutes   = time_q.minutes;
    assign o_seconds   = time_q.seconds;
    assign o_sec_pulse = sec_pulse_q;
    assign o_day_wrap  = day_wrap_q;

endmodule

// File: doc/time_keeper.md
Name: time_keeper

Overview:
Running time-of-day core that sits directly downstream of the time-setting stage. It consumes the set stage's hours/minutes and acknowledge pulse, then keeps 24-hour HH:MM:SS from a clk-derived 1 Hz tick. Counting freezes while setting is in progress. Its outputs feed the display/decode stage.

Parameters:
CLK_DIV, 50_000_000, clk cycles per second (minimum 2; benches use 4)
DIV_W, $clog2(CLK_DIV), prescaler counter width

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-low
hold  in  1  freeze counting (driven by set_time_en)
load  in  1  set-complete flag (driven by ack_flag); level input, rising edge acted on
i_hours  in  5  hours to load
i_minutes  in  6  minutes to load
o_hours  out  5  current hours, 0..23
o_minutes  out  6  current minutes, 0..59
o_seconds  out  6  current seconds, 0..59
o_sec_pulse  out  1  one-cycle pulse on each seconds advance
o_day_wrap  out  1  one-cycle pulse on 23:59:59 -> 00:00:00

Behaviour:
- Reset (rst=0, async): o_hours, o_minutes and o_seconds = 0. Prescaler = 0. load_d = 0. o_sec_pulse = 0. o_day_wrap = 0.
- Registers: o_sec_pulse and o_day_wrap are registered. They assert in the same cycle as the value change they flag.
- Prescaler:
  - Counts 0..CLK_DIV-1, +1 per clk while hold=0.
  - At CLK_DIV-1 it returns to 0 and raises an internal tick on that edge.
  - While hold=1, the prescaler is forced to 0 and no tick is produced. After hold falls, the first advance comes exactly CLK_DIV cycles later.
- Advance on tick:
  - seconds +1.
  - 59 -> 0 with minutes +1.
  - minutes 59 -> 0 with hours +1.
  - hours 23 -> 0.
  - o_sec_pulse=1 on every advance. o_day_wrap=1 only on the full 23:59:59 wrap.
- Load detect:
  - load_d <= load every cycle.
  - load_rise = load & ~load_d.
  - A level held high loads once only.
- On load_rise:
  - o_hours <= (i_hours<24) ? i_hours : 0.
  - o_minutes <= (i_minutes<60) ? i_minutes : 0.
  - o_seconds <= 0.
  - prescaler <= 0.
  - No pulses are generated.
- Priority, per cycle: load_rise > tick.
  - A coincident tick is discarded.
  - Load is accepted regardless of hold.
- Hold with no load: time values are held, and pulses stay 0.
- Range: time values never leave legal range. Out-of-range inputs to load are clamped to 0, not wrapped modulo.
- Reset mid-second: prescaler progress is lost. After release, the first advance is CLK_DIV cycles out.

Decomposition:
- Shared package clock_pkg:
  - HOURS_W=5, MIN_W=6, SEC_W=6.
  - HOURS_MAX=23, MIN_MAX=59, SEC_MAX=59.
  - The set stage and the display stage use the same package.
- One sub-module: tick_prescaler.
  - Parameter CLK_DIV.
  - Ports clk, rst, clr (hold | load_rise), tick.
  - Holds the counter and the terminal-count compare.
- Cascade counters and load logic stay in time_keeper.

Test Plan:
- Bench parameter: CLK_DIV=4.
- Reset, hold=0, run 12 cycles -> o_seconds steps 1,2,3 at cycles 4, 8 and 12. o_sec_pulse is high exactly those 3 cycles.
- Load 23:59 (pulse load one cycle), run 240 cycles -> at 60th advance the outputs read 00:00:00 and o_day_wrap=1 for one cycle. No other o_day_wrap.
- Drive i_hours=27, i_minutes=61, pulse load -> output 00:00:00. Drive i_hours=5, i_minutes=61 -> output 05:00:00.
- Hold high for 20 cycles mid-count -> no value change and no pulses. On release, next advance arrives exactly 4 cycles later.
- Load held high 10 cycles with inputs changing from 10:10 to 11:11 after cycle 1 -> 10:10:00 is latched and the later input is ignored. Assert load_rise on the same cycle as a tick -> loaded value appears and seconds=0, not 1.
- Assert rst low asynchronously mid-second at 12:34:56 -> all outputs 0 immediately. The first advance comes 4 cycles after rst rises.
